// File: rtl/aurora_tx_frame_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aurora_tx_frame_arbiter_pkg                                  |
// | Description : Shared constants, state encoding and helpers for the Aurora  |
// |               TX LocalLink frame arbiter.                                  |
// | Options     : AURORA_TX_ARB_WDOG_EN adds the DRAIN state encoding.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package aurora_tx_frame_arbiter_pkg;

  localparam int NUM_SRC             = 4;
  localparam int LL_DW               = 16;
  localparam int MAX_FRAME_BEATS_DEF = 1024;
  localparam int BEAT_CNT_W          = 11;

`ifdef AURORA_TX_ARB_WDOG_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1
  } arb_state_e;
`endif

  // Index of the set bit of a one-hot (or zero) 4-bit vector.
  function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [BEAT_CNT_W-1:0] sat_inc(input logic [BEAT_CNT_W-1:0] c);
    return (&c) ? c : c + BEAT_CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aurora_tx_frame_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aurora_rr_pick4                                              |
// | Description : Combinational 4-way round-robin picker. The first request    |
// |               found after the last granted index wins.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aurora_rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [3:0] gnt_o,
  output logic       valid_o
);

  logic [1:0] w_idx;

  // Scan last+1, last+2, last+3, last (wrapping) and take the first request.
  always_comb begin
    gnt_o   = 4'b0000;
    valid_o = 1'b0;
    w_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = last_i + 2'(k);
      if (!valid_o && req_i[w_idx]) begin
        gnt_o[w_idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aurora_tx_frame_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aurora_tx_frame_arbiter                                      |
// | Description : Round-robin frame arbiter muxing four LocalLink sources onto |
// |               one Aurora TX LocalLink port, whole frames at a time.        |
// | Options     : define AURORA_TX_ARB_WDOG_EN to enable the frame-length      |
// |               watchdog (forced EOF, WDOG_ABORT pulse, DRAIN state).        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aurora_tx_frame_arbiter
  import aurora_tx_frame_arbiter_pkg::*;
#(
  parameter int MAX_FRAME_BEATS = MAX_FRAME_BEATS_DEF
) (
  input  logic                      USER_CLK,
  input  logic                      RESET,
  input  logic                      CHANNEL_UP,
  input  logic [NUM_SRC*LL_DW-1:0]  SRC_D,
  input  logic [NUM_SRC-1:0]        SRC_REM,
  input  logic [NUM_SRC-1:0]        SRC_SOF_N,
  input  logic [NUM_SRC-1:0]        SRC_EOF_N,
  input  logic [NUM_SRC-1:0]        SRC_SRC_RDY_N,
  output logic [NUM_SRC-1:0]        SRC_DST_RDY_N,
  output logic [0:LL_DW-1]          TX_D,
  output logic                      TX_REM,
  output logic                      TX_SOF_N,
  output logic                      TX_EOF_N,
  output logic                      TX_SRC_RDY_N,
  input  logic                      TX_DST_RDY_N,
  output logic [NUM_SRC-1:0]        GRANT,
  output logic                      PROTO_ERR,
  output logic                      WDOG_ABORT
);

  // The beat counter is 11 bits, so the frame limit must fit below saturation.
  if (MAX_FRAME_BEATS < 1 || MAX_FRAME_BEATS > 2047) begin : g_bad_max_frame_beats
    $error("MAX_FRAME_BEATS must be within 1..2047");
  end

  arb_state_e              state_q, state_d;
  logic [NUM_SRC-1:0]      grant_q, grant_d;
  logic [1:0]              last_q, last_d;
  logic [BEAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    proto_err_q, proto_err_d;

  logic                    w_reset_c;
  logic [NUM_SRC-1:0]      w_req;
  logic [NUM_SRC-1:0]      w_bad;
  logic [NUM_SRC-1:0]      w_pick_gnt;
  logic                    w_pick_valid;
  logic [LL_DW-1:0]        w_g_d;
  logic                    w_g_rem;
  logic                    w_g_sof_n;
  logic                    w_g_eof_n;
  logic                    w_g_rdy_n;
  logic                    w_force_eof;

  // Channel loss behaves exactly like a reset.
  assign w_reset_c = RESET | ~CHANNEL_UP;

  // Frame starts compete for the grant; non-SOF beats seen while idle are protocol errors.
  assign w_req = ~SRC_SRC_RDY_N & ~SRC_SOF_N;
  assign w_bad = ~SRC_SRC_RDY_N &  SRC_SOF_N;

  // The last-granted index doubles as the mux select for the frame in flight.
  assign w_g_d     = SRC_D[{last_q, 4'b0000} +: LL_DW];
  assign w_g_rem   = SRC_REM[last_q];
  assign w_g_sof_n = SRC_SOF_N[last_q];
  assign w_g_eof_n = SRC_EOF_N[last_q];
  assign w_g_rdy_n = SRC_SRC_RDY_N[last_q];

  aurora_rr_pick4 u_pick (
    .req_i   (w_req),
    .last_i  (last_q),
    .gnt_o   (w_pick_gnt),
    .valid_o (w_pick_valid)
  );

`ifdef AURORA_TX_ARB_WDOG_EN
  localparam logic [BEAT_CNT_W-1:0] c_WDOG_LAST = BEAT_CNT_W'(MAX_FRAME_BEATS - 1);
  logic wdog_q, wdog_d;

  // The beat that would reach the limit without its own EOF gets an EOF forced on it.
  assign w_force_eof = (cnt_q == c_WDOG_LAST) & w_g_eof_n;
  assign WDOG_ABORT  = wdog_q;
`else
  assign w_force_eof = 1'b0;
  assign WDOG_ABORT  = 1'b0;
`endif

  assign GRANT     = grant_q;
  assign PROTO_ERR = proto_err_q;

  // Next-state logic and LocalLink steering for both directions.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    proto_err_d   = 1'b0;
`ifdef AURORA_TX_ARB_WDOG_EN
    wdog_d        = 1'b0;
`endif
    TX_D          = '0;
    TX_REM        = 1'b1;
    TX_SOF_N      = 1'b1;
    TX_EOF_N      = 1'b1;
    TX_SRC_RDY_N  = 1'b1;
    SRC_DST_RDY_N = '1;

    case (state_q)
      ST_IDLE: begin
        cnt_d         = '0;
        SRC_DST_RDY_N = ~w_bad;
        proto_err_d   = |w_bad;
        if (w_pick_valid) begin
          grant_d = w_pick_gnt;
          last_d  = onehot4_to_idx(w_pick_gnt);
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        TX_D                  = w_g_d;
        TX_REM                = w_g_rem;
        TX_SOF_N              = w_g_sof_n;
        TX_EOF_N              = w_g_eof_n & ~w_force_eof;
        TX_SRC_RDY_N          = w_g_rdy_n;
        SRC_DST_RDY_N[last_q] = TX_DST_RDY_N;
        if (!w_g_rdy_n && !TX_DST_RDY_N) begin
          cnt_d = sat_inc(cnt_q);
          // A second SOF inside a frame is passed through but flagged.
          if (!w_g_sof_n && (cnt_q != '0)) proto_err_d = 1'b1;
          if (!w_g_eof_n) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
`ifdef AURORA_TX_ARB_WDOG_EN
          else if (w_force_eof) begin
            wdog_d  = 1'b1;
            state_d = ST_DRAIN;
          end
`endif
        end
      end

`ifdef AURORA_TX_ARB_WDOG_EN
      ST_DRAIN: begin
        // Swallow the rest of the oversized frame without forwarding it.
        SRC_DST_RDY_N[last_q] = 1'b0;
        if (!w_g_rdy_n && !w_g_eof_n) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    if (w_reset_c) begin
      TX_D          = '0;
      TX_REM        = 1'b1;
      TX_SOF_N      = 1'b1;
      TX_EOF_N      = 1'b1;
      TX_SRC_RDY_N  = 1'b1;
      SRC_DST_RDY_N = '1;
    end
  end

  // State register; reset leaves source 0 first in round-robin order.
  always_ff @(posedge USER_CLK) begin
    if (w_reset_c) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= 2'd3;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
`ifdef AURORA_TX_ARB_WDOG_EN
      wdog_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
`ifdef AURORA_TX_ARB_WDOG_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aurora_tx_frame_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_aurora_tx_frame_arbiter                                   |
// | Description : Directed scoreboard bench for aurora_tx_frame_arbiter.       |
// | Options     : AURORA_TX_ARB_WDOG_EN selects MAX_FRAME_BEATS=8 and adds the |
// |               watchdog scenario.                                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_aurora_tx_frame_arbiter;

`ifdef AURORA_TX_ARB_WDOG_EN
  localparam int TB_MAX = 8;
`else
  localparam int TB_MAX = 1024;
`endif
  localparam int FLEN = (TB_MAX < 9) ? TB_MAX : 9;

  typedef struct packed {
    logic [15:0] d;
    logic        rem;
    logic        sof_n;
    logic        eof_n;
  } beat_t;

  logic        clk;
  logic        RESET;
  logic        CHANNEL_UP;
  logic [63:0] SRC_D;
  logic [3:0]  SRC_REM;
  logic [3:0]  SRC_SOF_N;
  logic [3:0]  SRC_EOF_N;
  logic [3:0]  SRC_SRC_RDY_N;
  logic [3:0]  SRC_DST_RDY_N;
  logic [0:15] TX_D;
  logic        TX_REM;
  logic        TX_SOF_N;
  logic        TX_EOF_N;
  logic        TX_SRC_RDY_N;
  logic        TX_DST_RDY_N;
  logic [3:0]  GRANT;
  logic        PROTO_ERR;
  logic        WDOG_ABORT;

  beat_t       srcq [4][$];
  beat_t       expq [$];
  logic [3:0]  grant_log [$];
  logic [3:0]  prev_grant = 4'h0;
  beat_t       mon_e;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int tx_beats = 0;
  int tx_sof = 0;
  int tx_eof = 0;
  int proto_cnt = 0;
  int wdog_cnt = 0;
  int first_cyc = -1;
  int last_cyc = 0;

  aurora_tx_frame_arbiter #(.MAX_FRAME_BEATS(TB_MAX)) dut (
    .USER_CLK      (clk),
    .RESET         (RESET),
    .CHANNEL_UP    (CHANNEL_UP),
    .SRC_D         (SRC_D),
    .SRC_REM       (SRC_REM),
    .SRC_SOF_N     (SRC_SOF_N),
    .SRC_EOF_N     (SRC_EOF_N),
    .SRC_SRC_RDY_N (SRC_SRC_RDY_N),
    .SRC_DST_RDY_N (SRC_DST_RDY_N),
    .TX_D          (TX_D),
    .TX_REM        (TX_REM),
    .TX_SOF_N      (TX_SOF_N),
    .TX_EOF_N      (TX_EOF_N),
    .TX_SRC_RDY_N  (TX_SRC_RDY_N),
    .TX_DST_RDY_N  (TX_DST_RDY_N),
    .GRANT         (GRANT),
    .PROTO_ERR     (PROTO_ERR),
    .WDOG_ABORT    (WDOG_ABORT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // TX-side monitor: pops the scoreboard on every transfer and tallies pulses.
  always @(negedge clk) begin
    cyc++;
    if (PROTO_ERR === 1'b1) proto_cnt++;
    if (WDOG_ABORT === 1'b1) wdog_cnt++;
    if (GRANT !== 4'h0 && prev_grant === 4'h0) grant_log.push_back(GRANT);
    prev_grant = GRANT;
    if (TX_SRC_RDY_N === 1'b0 && TX_DST_RDY_N === 1'b0) begin
      tx_beats++;
      if (TX_SOF_N === 1'b0) tx_sof++;
      if (TX_EOF_N === 1'b0) tx_eof++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (expq.size() == 0) begin
        chk("tx_unexpected_beat", 32'(expq.size()), 32'd1);
      end else begin
        mon_e = expq.pop_front();
        chk("tx_beat", 32'({TX_D, TX_REM, TX_SOF_N, TX_EOF_N}),
            32'({mon_e.d, mon_e.rem, mon_e.sof_n, mon_e.eof_n}));
      end
    end
  end

  task automatic load_frame(input int n, input int len, input logic [15:0] base, input bit push_exp);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.d     = base + 16'(i);
      b.rem   = 1'b1;
      b.sof_n = (i != 0);
      b.eof_n = (i != len - 1);
      srcq[n].push_back(b);
      if (push_exp) expq.push_back(b);
    end
  endtask

  task automatic apply_src();
    for (int n = 0; n < 4; n++) begin
      if (srcq[n].size() > 0) begin
        SRC_D[16*n +: 16] = srcq[n][0].d;
        SRC_REM[n]        = srcq[n][0].rem;
        SRC_SOF_N[n]      = srcq[n][0].sof_n;
        SRC_EOF_N[n]      = srcq[n][0].eof_n;
        SRC_SRC_RDY_N[n]  = 1'b0;
      end else begin
        SRC_D[16*n +: 16] = 16'h0000;
        SRC_REM[n]        = 1'b1;
        SRC_SOF_N[n]      = 1'b1;
        SRC_EOF_N[n]      = 1'b1;
        SRC_SRC_RDY_N[n]  = 1'b1;
      end
    end
  endtask

  task automatic step(input bit toggle);
    logic [3:0] acc;
    @(negedge clk);
    acc = ~SRC_SRC_RDY_N & ~SRC_DST_RDY_N;
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      if (acc[n] && srcq[n].size() > 0) void'(srcq[n].pop_front());
    end
    apply_src();
    if (toggle) TX_DST_RDY_N = ~TX_DST_RDY_N;
    else        TX_DST_RDY_N = 1'b0;
  endtask

  task automatic run(input int budget, input bit toggle, input string tag);
    int k;
    k = 0;
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size()
            + expq.size()) > 0 && k < budget) begin
      step(toggle);
      k++;
    end
    chk({tag, "_done"}, 32'(k < budget), 32'd1);
    repeat (3) step(1'b0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    for (int n = 0; n < 4; n++) srcq[n].delete();
    expq.delete();
    apply_src();
    TX_DST_RDY_N = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    RESET = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    beat_t b;
    RESET        = 1'b1;
    CHANNEL_UP   = 1'b1;
    TX_DST_RDY_N = 1'b0;
    apply_src();
    // A stray non-SOF beat during reset must not be accepted.
    SRC_SRC_RDY_N[3] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant",      32'(GRANT),         32'h0);
    chk("rst_tx_rdy_n",   32'(TX_SRC_RDY_N),  32'h1);
    chk("rst_tx_sof_n",   32'(TX_SOF_N),      32'h1);
    chk("rst_tx_eof_n",   32'(TX_EOF_N),      32'h1);
    chk("rst_tx_rem",     32'(TX_REM),        32'h1);
    chk("rst_tx_d",       32'(TX_D),          32'h0);
    chk("rst_src_dst",    32'(SRC_DST_RDY_N), 32'hF);
    chk("rst_proto",      32'(PROTO_ERR),     32'h0);
    chk("rst_wdog",       32'(WDOG_ABORT),    32'h0);
    @(posedge clk);
    #1;
    apply_src();
    RESET = 1'b0;

    // Two simultaneous frames: source 0 first, then source 2, no interleave.
    grant_log.delete();
    tx_beats = 0; tx_sof = 0; tx_eof = 0;
    load_frame(0, FLEN, 16'h0100, 1'b1);
    load_frame(2, FLEN, 16'h0200, 1'b1);
    apply_src();
    run(200, 1'b0, "two_src");
    chk("two_src_beats", 32'(tx_beats), 32'(2 * FLEN));
    chk("two_src_sof",   32'(tx_sof),   32'd2);
    chk("two_src_eof",   32'(tx_eof),   32'd2);
    chk("two_src_ngrant", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("two_src_g0", 32'(grant_log[0]), 32'h1);
      chk("two_src_g1", 32'(grant_log[1]), 32'h4);
    end

    // All four sources stream single-beat frames: strict rotation, one idle cycle apart.
    do_reset();
    grant_log.delete();
    first_cyc = -1;
    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < 4; s++) load_frame(s, 1, 16'h1000 + 16'(r * 16 + s), 1'b1);
    end
    apply_src();
    run(200, 1'b0, "rr4");
    chk("rr4_ngrant", 32'(grant_log.size()), 32'd8);
    if (grant_log.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("rr4_order", 32'(grant_log[i]), 32'(4'b0001 << (i % 4)));
    end
    chk("rr4_span", 32'(last_cyc - first_cyc), 32'd14);

    // Back-pressure toggling on TX must neither lose nor duplicate beats.
    tx_beats = 0;
    load_frame(1, FLEN, 16'h0001, 1'b1);
    apply_src();
    run(200, 1'b1, "bp");
    chk("bp_beats", 32'(tx_beats), 32'(FLEN));

    // Repeated SOF inside a frame is forwarded unchanged and flagged once.
    p0 = proto_cnt;
    load_frame(2, 4, 16'h0500, 1'b0);
    srcq[2][2].sof_n = 1'b0;
    for (int i = 0; i < 4; i++) expq.push_back(srcq[2][i]);
    apply_src();
    run(100, 1'b0, "midsof");
    chk("midsof_proto", 32'(proto_cnt - p0), 32'd1);

    // Channel loss at beat 4 abandons the frame; a new frame is then granted.
    load_frame(1, FLEN, 16'h0300, 1'b0);
    for (int i = 0; i < 3; i++) expq.push_back(srcq[1][i]);
    apply_src();
    begin
      int k;
      k = 0;
      while (srcq[1].size() > FLEN - 3 && k < 100) begin
        step(1'b0);
        k++;
      end
      chk("chdown_reach_beat4", 32'(k < 100), 32'd1);
    end
    CHANNEL_UP = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("chdown_grant",   32'(GRANT),         32'h0);
    chk("chdown_src_dst", 32'(SRC_DST_RDY_N), 32'hF);
    chk("chdown_tx_rdy",  32'(TX_SRC_RDY_N),  32'h1);
    chk("chdown_partial", 32'(expq.size()),   32'd0);
    @(posedge clk);
    #1;
    srcq[1].delete();
    apply_src();
    @(posedge clk);
    #1;
    CHANNEL_UP = 1'b1;
    grant_log.delete();
    load_frame(1, 3, 16'h0400, 1'b1);
    apply_src();
    run(100, 1'b0, "chup");
    chk("chup_ngrant", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() == 1) chk("chup_grant", 32'(grant_log[0]), 32'h2);

    // Non-SOF beat from source 3 while idle: dropped, one PROTO_ERR pulse.
    p0 = tx_beats;
    SRC_SRC_RDY_N[3] = 1'b0;
    SRC_SOF_N[3]     = 1'b1;
    SRC_EOF_N[3]     = 1'b1;
    @(negedge clk);
    chk("drop_src_dst", 32'(SRC_DST_RDY_N), 32'h7);
    chk("drop_tx_rdy",  32'(TX_SRC_RDY_N),  32'h1);
    @(posedge clk);
    #1;
    apply_src();
    @(negedge clk);
    chk("drop_proto_hi", 32'(PROTO_ERR), 32'h1);
    chk("drop_grant",    32'(GRANT),     32'h0);
    @(negedge clk);
    chk("drop_proto_lo", 32'(PROTO_ERR), 32'h0);
    chk("drop_no_tx",    32'(tx_beats - p0), 32'd0);
    @(posedge clk);
    #1;

`ifdef AURORA_TX_ARB_WDOG_EN
    // 12-beat frame against an 8-beat limit: forced EOF, abort pulse, drain.
    p0 = wdog_cnt;
    tx_beats = 0;
    tx_eof   = 0;
    load_frame(0, 12, 16'h0A00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      b = srcq[0][i];
      if (i == 7) b.eof_n = 1'b0;
      expq.push_back(b);
    end
    apply_src();
    run(200, 1'b0, "wdog");
    chk("wdog_beats", 32'(tx_beats), 32'd8);
    chk("wdog_eof",   32'(tx_eof),   32'd1);
    chk("wdog_pulse", 32'(wdog_cnt - p0), 32'd1);
    chk("wdog_idle",  32'(GRANT),    32'h0);
`else
    b = '0;
    chk("wdog_never", 32'(wdog_cnt) | 32'(b), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aurora_tx_frame_arbiter.md
AURORA_TX_FRAME_ARBITER -- requirements
Module: aurora_tx_frame_arbiter

Interface
REQ-001 SHALL have ports: USER_CLK in 1, sole clock; RESET in 1, synchronous active-high reset.
REQ-002 SHALL have ports: CHANNEL_UP in 1, Aurora channel ready; low acts as reset_c = RESET or not CHANNEL_UP.
REQ-003 SHALL have per-source LocalLink inputs (4 sources, index n=0..3): SRC_D in 64 (source n on bits 16n+15:16n); SRC_REM in 4; SRC_SOF_N in 4; SRC_EOF_N in 4; SRC_SRC_RDY_N in 4.
REQ-004 SHALL have per-source output SRC_DST_RDY_N out 4, active-low accept, one bit per source.
REQ-005 SHALL have Aurora-side ports TX_D out [0:15], TX_REM out 1, TX_SOF_N out 1, TX_EOF_N out 1, TX_SRC_RDY_N out 1, and TX_DST_RDY_N in 1.
REQ-006 SHALL have status outputs GRANT out 4 (one-hot or zero), PROTO_ERR out 1 (one-cycle pulse), WDOG_ABORT out 1 (one-cycle pulse).
REQ-007 SHALL have parameter MAX_FRAME_BEATS, default 1024, meaning maximum accepted beats per frame, EOF beat included.

Function
REQ-008 SHALL implement FSM states IDLE, GRANT, DRAIN; a beat transfers on a cycle when the forwarded TX_SRC_RDY_N=0 and TX_DST_RDY_N=0.
REQ-009 IDLE: candidate = source with SRC_SRC_RDY_N=0 and SRC_SOF_N=0; the next candidate round-robin after the last granted index wins; registered GRANT takes effect next cycle (1-cycle arbitration latency); go to GRANT.
REQ-010 IDLE: TX_SRC_RDY_N=1 and no beat forwarded.
REQ-011 IDLE: any source with SRC_SRC_RDY_N=0 and SRC_SOF_N=1 SHALL get SRC_DST_RDY_N=0 (beat dropped) with PROTO_ERR pulsed the next cycle; candidates SHALL see SRC_DST_RDY_N=1.
REQ-012 GRANT: TX_D, TX_REM, TX_SOF_N, TX_EOF_N, TX_SRC_RDY_N SHALL be combinational copies of the granted source; its SRC_DST_RDY_N = TX_DST_RDY_N; others SHALL see 1.
REQ-013 GRANT: on a transfer with EOF_N=0, go to IDLE next cycle, keep last-granted index, and clear GRANT.
REQ-014 GRANT: SRC_SRC_RDY_N=1 gaps mid-frame SHALL hold the grant indefinitely.
REQ-015 GRANT: a transferred beat with SOF_N=0 after the first beat SHALL be forwarded unchanged, and PROTO_ERR SHALL pulse.
REQ-016 Single-beat frame (SOF_N=0 and EOF_N=0 together) SHALL be legal and return to IDLE.
REQ-017 Beat counter SHALL be 11 bits wide, clear in IDLE, increment per transferred beat, and saturate.
REQ-018 When CHANNEL_UP falls mid-frame: next cycle state IDLE, GRANT=0, all SRC_DST_RDY_N=1, TX_SRC_RDY_N=1; the partial frame is abandoned; last-granted index is kept.

Reset
REQ-019 On reset_c: state IDLE, GRANT=0, last-granted index=3 (so source 0 wins first), beat counter=0, PROTO_ERR=0, WDOG_ABORT=0.
REQ-020 During reset_c: TX_SRC_RDY_N=1, TX_SOF_N=1, TX_EOF_N=1, TX_REM=1, TX_D=16'h0000, SRC_DST_RDY_N=4'hF.

Configuration
REQ-021 Macro AURORA_TX_ARB_WDOG_EN SHALL compile in the frame-length watchdog.
REQ-022 With the macro defined: in GRANT, the transfer that makes the count equal MAX_FRAME_BEATS without source EOF SHALL carry forced TX_EOF_N=0.
REQ-023 With the macro defined, after that forced EOF: WDOG_ABORT SHALL pulse and the state SHALL go to DRAIN.
REQ-024 DRAIN (macro defined only): the granted source sees SRC_DST_RDY_N=0; its beats are discarded with TX_SRC_RDY_N=1 until its EOF beat, then IDLE.
REQ-025 Without the macro: no DRAIN state, WDOG_ABORT tied 0, frames of unlimited length.

Structure
REQ-026 A shared package/header SHALL hold state encodings, NUM_SRC=4, LocalLink data width 16, and the MAX_FRAME_BEATS default.
REQ-027 The round-robin picker SHALL be one sub-module aurora_rr_pick4 (request 4, last index 2 -> grant one-hot 4, valid), purely combinational.

Verification
REQ-028 Sources 0 and 2 each present a 9-beat frame simultaneously after reset -> source 0 is sent first, then source 2; TX sees 18 beats, 2 SOF, 2 EOF, with no interleave.
REQ-029 All 4 sources continuously request 1-beat frames -> grant order 0,1,2,3,0.., one idle cycle between frames.
REQ-030 TX_DST_RDY_N toggles 1/0 during a granted 9-beat frame with payload 0001..0009 -> TX_D sequence exact, with no beat lost or duplicated.
REQ-031 CHANNEL_UP=0 at beat 4 of a frame from source 1 -> next cycle GRANT=0, SRC_DST_RDY_N=4'hF, and TX_SRC_RDY_N=1; after CHANNEL_UP=1 a new SOF from source 1 is granted.
REQ-032 Source 3 holds SRC_SRC_RDY_N=0 and SRC_SOF_N=1 in IDLE -> beat dropped, PROTO_ERR=1 for one cycle, no TX activity.
REQ-033 With AURORA_TX_ARB_WDOG_EN and MAX_FRAME_BEATS=8, a 12-beat frame -> TX gets 8 beats with EOF on the 8th, WDOG_ABORT pulses once, 4 beats drained, then IDLE.
